// File: rtl/deflect_route_stage_pkg.sv
// Shared types and helpers for the bufferless deflection router stage.
// Direction codes index the link ports directly; DIR_L marks local ejection.
package deflect_route_stage_pkg;

   localparam int NPORT = 4;
   localparam int NSLOT = 5;

   typedef enum logic [2:0] {
      DIR_N    = 3'd0,
      DIR_S    = 3'd1,
      DIR_E    = 3'd2,
      DIR_W    = 3'd3,
      DIR_L    = 3'd4,
      DIR_NONE = 3'd7
   } dir_e;

   typedef struct packed {
      dir_e prim;
      dir_e sec;
      logic loc;
   } route_t;

   // Link directions map to a one-hot port mask; local/none map to no port.
   function automatic logic [NPORT-1:0] dir_onehot(input dir_e d);
      logic [NPORT-1:0] r;
      case (d)
         DIR_N:   r = 4'b0001;
         DIR_S:   r = 4'b0010;
         DIR_E:   r = 4'b0100;
         DIR_W:   r = 4'b1000;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

   function automatic logic [NPORT-1:0] lowest_onehot(input logic [NPORT-1:0] m);
      return m & (~m + NPORT'(1));
   endfunction

endpackage

// File: rtl/deflect_route_stage_if.sv
// Link, injection and ejection signals of one router node.
// master drives link inputs and injection; slave is the router.
interface deflect_route_stage_if #(
   parameter int FLIT_W = 16,
   parameter int CNT_W  = 16
);
   logic [FLIT_W-1:0] nty, sty, ety, wty;
   logic              inj_valid;
   logic [FLIT_W-1:0] inj_flit;
   logic              inj_ready;
   logic [FLIT_W-1:0] nxt, sxt, ext, wxt;
   logic              ej_valid;
   logic [FLIT_W-1:0] ej_flit;
   logic [CNT_W-1:0]  defl_cnt;

   modport master (
      output nty, sty, ety, wty, inj_valid, inj_flit,
      input  inj_ready, nxt, sxt, ext, wxt, ej_valid, ej_flit, defl_cnt
   );

   modport slave (
      input  nty, sty, ety, wty, inj_valid, inj_flit,
      output inj_ready, nxt, sxt, ext, wxt, ej_valid, ej_flit, defl_cnt
   );
endinterface

// File: rtl/deflect_route_stage_route_compute.sv
// XY route lookup: X is the primary productive direction, Y the secondary,
// and Y becomes primary once X already matches this node.
module route_compute
   import deflect_route_stage_pkg::*;
#(
   parameter int COORD_W = 2,
   parameter int MY_X    = 0,
   parameter int MY_Y    = 0
) (
   input  logic [COORD_W-1:0] i_dst_x,
   input  logic [COORD_W-1:0] i_dst_y,
   output route_t             o_route
);

   localparam logic [COORD_W-1:0] LX = COORD_W'(MY_X);
   localparam logic [COORD_W-1:0] LY = COORD_W'(MY_Y);

   dir_e w_xdir, w_ydir;

   always_comb begin
      w_xdir = DIR_NONE;
      w_ydir = DIR_NONE;
      if (i_dst_x > LX)      w_xdir = DIR_E;
      else if (i_dst_x < LX) w_xdir = DIR_W;
      if (i_dst_y > LY)      w_ydir = DIR_N;
      else if (i_dst_y < LY) w_ydir = DIR_S;

      o_route.loc  = (w_xdir == DIR_NONE) && (w_ydir == DIR_NONE);
      o_route.prim = o_route.loc ? DIR_L : ((w_xdir != DIR_NONE) ? w_xdir : w_ydir);
      o_route.sec  = (w_xdir != DIR_NONE) ? w_ydir : DIR_NONE;
   end

endmodule

// File: rtl/deflect_route_stage.sv
// Two-stage bufferless deflection router: stage 1 captures links + injection
// with their routes, stage 2 ranks by age, ejects, allocates and registers outputs.
module deflect_route_stage
   import deflect_route_stage_pkg::*;
#(
   parameter int FLIT_W  = 16,
   parameter int COORD_W = 2,
   parameter int AGE_W   = 3,
   parameter int MY_X    = 0,
   parameter int MY_Y    = 0,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   deflect_route_stage_if.slave bus
);

   localparam int VB      = FLIT_W - 1;
   localparam int AGE_LSB = FLIT_W - 1 - AGE_W;
   localparam int DX_LSB  = AGE_LSB - COORD_W;
   localparam int DY_LSB  = DX_LSB - COORD_W;
   localparam int CW1     = CNT_W + 1;
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   logic [NPORT-1:0][FLIT_W-1:0] w_lnk;
   logic [NPORT-1:0]             w_lvalid;
   logic                         w_inj_ready, w_inj_acc;
   logic [NSLOT-1:0][FLIT_W-1:0] w_slot;
   route_t [NSLOT-1:0]           w_route;
   logic                         w_unused;

   logic [NSLOT-1:0][FLIT_W-1:0] r_s1_flit;
   route_t [NSLOT-1:0]           r_s1_route;

   assign w_lnk       = {bus.wty, bus.ety, bus.sty, bus.nty};
   assign w_lvalid    = {bus.wty[VB], bus.ety[VB], bus.sty[VB], bus.nty[VB]};
   assign w_inj_ready = ~&w_lvalid;
   assign w_inj_acc   = bus.inj_valid & w_inj_ready;
   assign bus.inj_ready = w_inj_ready;
   assign w_unused    = ^bus.inj_flit[FLIT_W-1:AGE_LSB];

   // Invalid slots are zeroed so stray bits never reach ranking or outputs.
   always_comb begin
      w_slot = '0;
      for (int i = 0; i < NPORT; i++)
         if (w_lvalid[i]) w_slot[i] = w_lnk[i];
      if (w_inj_acc)
         w_slot[NPORT] = {1'b1, {AGE_W{1'b0}}, bus.inj_flit[AGE_LSB-1:0]};
   end

   for (genvar g = 0; g < NSLOT; g++) begin : g_rc
      route_compute #(.COORD_W(COORD_W), .MY_X(MY_X), .MY_Y(MY_Y)) u_rc (
         .i_dst_x (w_slot[g][DX_LSB +: COORD_W]),
         .i_dst_y (w_slot[g][DY_LSB +: COORD_W]),
         .o_route (w_route[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_flit  <= '0;
         r_s1_route <= '0;
      end else begin
         r_s1_flit  <= w_slot;
         r_s1_route <= w_route;
      end
   end

   logic [NSLOT-1:0]             w_v;
   logic [NSLOT-1:0][2:0]        w_rank;
   logic [NPORT-1:0]             w_free, w_pick;
   logic [NPORT-1:0][FLIT_W-1:0] w_out;
   logic [FLIT_W-1:0]            w_f, w_ej_f;
   logic                         w_ej_hit;
   logic [2:0]                   w_ndefl;

   // Rank = number of valid slots that beat this one (older, or same age and lower index).
   always_comb begin
      w_rank = '0;
      for (int s = 0; s < NSLOT; s++) begin
         w_v[s] = r_s1_flit[s][VB];
         for (int j = 0; j < NSLOT; j++)
            if (j != s && r_s1_flit[j][VB] &&
                ((r_s1_flit[j][AGE_LSB +: AGE_W] > r_s1_flit[s][AGE_LSB +: AGE_W]) ||
                 ((r_s1_flit[j][AGE_LSB +: AGE_W] == r_s1_flit[s][AGE_LSB +: AGE_W]) && j < s)))
               w_rank[s] = w_rank[s] + 3'd1;
      end
   end

   // Walk ranks in order; each flit takes primary, then secondary, then the lowest free port.
   always_comb begin
      w_free   = '1;
      w_pick   = '0;
      w_out    = '0;
      w_f      = '0;
      w_ej_f   = '0;
      w_ej_hit = 1'b0;
      w_ndefl  = '0;
      for (int p = 0; p < NSLOT; p++) begin
         for (int s = 0; s < NSLOT; s++) begin
            if (w_v[s] && w_rank[s] == 3'(p)) begin
               w_f = r_s1_flit[s];
               if (r_s1_route[s].loc && !w_ej_hit) begin
                  w_ej_hit = 1'b1;
                  w_ej_f   = w_f;
               end else begin
                  w_pick = dir_onehot(r_s1_route[s].prim) & w_free;
                  if (w_pick == '0)
                     w_pick = dir_onehot(r_s1_route[s].sec) & w_free;
                  if (w_pick == '0) begin
                     w_pick = lowest_onehot(w_free);
                     if (w_f[AGE_LSB +: AGE_W] != AGE_MAX)
                        w_f[AGE_LSB +: AGE_W] = w_f[AGE_LSB +: AGE_W] + 1'b1;
                     w_ndefl = w_ndefl + 3'd1;
                  end
                  for (int q = 0; q < NPORT; q++)
                     if (w_pick[q]) w_out[q] = w_f;
                  w_free = w_free & ~w_pick;
               end
            end
         end
      end
   end

   logic [NPORT-1:0][FLIT_W-1:0] r_out;
   logic                         r_ej_valid;
   logic [FLIT_W-1:0]            r_ej_flit;
   logic [CNT_W-1:0]             r_defl_cnt;
   logic [CNT_W:0]               w_cnt_sum;

   assign w_cnt_sum = {1'b0, r_defl_cnt} + CW1'(w_ndefl);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out      <= '0;
         r_ej_valid <= 1'b0;
         r_ej_flit  <= '0;
         r_defl_cnt <= '0;
      end else begin
         r_out      <= w_out;
         r_ej_valid <= w_ej_hit;
         r_ej_flit  <= w_ej_f;
         r_defl_cnt <= w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];
      end
   end

   assign bus.nxt      = r_out[0];
   assign bus.sxt      = r_out[1];
   assign bus.ext      = r_out[2];
   assign bus.wxt      = r_out[3];
   assign bus.ej_valid = r_ej_valid;
   assign bus.ej_flit  = r_ej_flit;
   assign bus.defl_cnt = r_defl_cnt;

endmodule
